cpu_bus_arbiter: RTL and testbench

Merges the CPU's separate instruction bus and data bus onto one shared memory bus, for single-port memory systems. Grants one requester at a time and holds the grant until the transfer completes. Returns rdata and a one-cycle ready to the granted side only. A watchdog aborts hung transfers and raises a sticky fault.

---
 rtl/cpu_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the CPU instruction and data buses onto one shared memory bus, with a watchdog.
// Optional per-side grant and contention counters are enabled by CPU_BUS_ARBITER_STATS_EN.
module cpu_bus_arbiter #(
    parameter int unsigned PRIORITY = 0,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned TW       = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    output logic        o_ibus_ready,
    input  logic [31:0] i_ibus_address,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_rw,
    input  logic        i_dbus_request,
    output logic        o_dbus_ready,
    input  logic [31:0] i_dbus_address,
    output logic [31:0] o_dbus_rdata,
    input  logic [31:0] i_dbus_wdata,
    input  logic [3:0]  i_dbus_wmask,
    output logic        o_bus_rw,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    output logic        o_fault,
    output logic [1:0]  o_grant
`ifdef CPU_BUS_ARBITER_STATS_EN
    ,
    output logic [31:0] o_stat_igrants,
    output logic [31:0] o_stat_dgrants,
    output logic [31:0] o_stat_contention
`endif
);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDone} state_e;

    state_e       state_q, state_d;
    logic         bus_request_q, bus_request_d;
    logic         bus_rw_q, bus_rw_d;
    logic [31:0]  bus_address_q, bus_address_d;
    logic [31:0]  bus_wdata_q, bus_wdata_d;
    logic [3:0]   bus_wmask_q, bus_wmask_d;
    logic         ibus_ready_q, ibus_ready_d;
    logic         dbus_ready_q, dbus_ready_d;
    logic [31:0]  ibus_rdata_q, ibus_rdata_d;
    logic [31:0]  dbus_rdata_q, dbus_rdata_d;
    logic         fault_q, fault_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    // 1: dbus wins the next tie under round-robin.
    logic         rr_q, rr_d;
    logic         pick_dbus;
    logic         timeout_hit;
    logic [31:0]  done_rdata;

    assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));
    assign done_rdata  = i_bus_ready ? i_bus_rdata : 32'h0;

    always_comb begin
        state_d       = state_q;
        bus_request_d = bus_request_q;
        bus_rw_d      = bus_rw_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        bus_wmask_d   = bus_wmask_q;
        ibus_ready_d  = 1'b0;
        dbus_ready_d  = 1'b0;
        ibus_rdata_d  = ibus_rdata_q;
        dbus_rdata_d  = dbus_rdata_q;
        fault_d       = fault_q;
        tcnt_d        = tcnt_q;
        rr_d          = rr_q;
        pick_dbus     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_ibus_request && i_dbus_request) begin
                    pick_dbus = (PRIORITY != 0) ? 1'b1 : rr_q;
                end else begin
                    pick_dbus = i_dbus_request;
                end
                if (i_ibus_request || i_dbus_request) begin
                    bus_request_d = 1'b1;
                    tcnt_d        = '0;
                    rr_d          = ~pick_dbus;
                    if (pick_dbus) begin
                        state_d       = StGrantD;
                        bus_rw_d      = i_dbus_rw;
                        bus_address_d = i_dbus_address;
                        bus_wdata_d   = i_dbus_wdata;
                        bus_wmask_d   = i_dbus_wmask;
                    end else begin
                        state_d       = StGrantI;
                        bus_rw_d      = 1'b0;
                        bus_address_d = i_ibus_address;
                        bus_wdata_d   = 32'h0;
                        bus_wmask_d   = 4'h0;
                    end
                end
            end
            StGrantI, StGrantD: begin
                // A watchdog abort completes like a normal transfer but returns zero data.
                if (i_bus_ready || timeout_hit) begin
                    bus_request_d = 1'b0;
                    state_d       = StDone;
                    if (!i_bus_ready) begin
                        fault_d = 1'b1;
                    end
                    if (state_q == StGrantD) begin
                        dbus_ready_d = 1'b1;
                        dbus_rdata_d = done_rdata;
                    end else begin
                        ibus_ready_d = 1'b1;
                        ibus_rdata_d = done_rdata;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= StIdle;
            bus_request_q <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= 32'h0;
            bus_wdata_q   <= 32'h0;
            bus_wmask_q   <= 4'h0;
            ibus_ready_q  <= 1'b0;
            dbus_ready_q  <= 1'b0;
            ibus_rdata_q  <= 32'h0;
            dbus_rdata_q  <= 32'h0;
            fault_q       <= 1'b0;
            tcnt_q        <= '0;
            rr_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            bus_request_q <= bus_request_d;
            bus_rw_q      <= bus_rw_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_wmask_q   <= bus_wmask_d;
            ibus_ready_q  <= ibus_ready_d;
            dbus_ready_q  <= dbus_ready_d;
            ibus_rdata_q  <= ibus_rdata_d;
            dbus_rdata_q  <= dbus_rdata_d;
            fault_q       <= fault_d;
            tcnt_q        <= tcnt_d;
            rr_q          <= rr_d;
        end
    end

    assign o_bus_request = bus_request_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_address_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_bus_wmask   = bus_wmask_q;
    assign o_ibus_ready  = ibus_ready_q;
    assign o_dbus_ready  = dbus_ready_q;
    assign o_ibus_rdata  = ibus_rdata_q;
    assign o_dbus_rdata  = dbus_rdata_q;
    assign o_fault       = fault_q;
    assign o_grant       = (state_q == StGrantI) ? 2'b01 :
                           (state_q == StGrantD) ? 2'b10 : 2'b00;

`ifdef CPU_BUS_ARBITER_STATS_EN
    logic [31:0] stat_ig_q, stat_ig_d;
    logic [31:0] stat_dg_q, stat_dg_d;
    logic [31:0] stat_ct_q, stat_ct_d;

    always_comb begin
        stat_ig_d = stat_ig_q;
        stat_dg_d = stat_dg_q;
        stat_ct_d = stat_ct_q;
        if (state_d == StGrantI && state_q == StIdle && stat_ig_q != 32'hFFFF_FFFF) begin
            stat_ig_d = stat_ig_q + 32'd1;
        end
        if (state_d == StGrantD && state_q == StIdle && stat_dg_q != 32'hFFFF_FFFF) begin
            stat_dg_d = stat_dg_q + 32'd1;
        end
        if (state_q == StIdle && i_ibus_request && i_dbus_request &&
            stat_ct_q != 32'hFFFF_FFFF) begin
            stat_ct_d = stat_ct_q + 32'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            stat_ig_q <= 32'h0;
            stat_dg_q <= 32'h0;
            stat_ct_q <= 32'h0;
        end else begin
            stat_ig_q <= stat_ig_d;
            stat_dg_q <= stat_dg_d;
            stat_ct_q <= stat_ct_d;
        end
    end

    assign o_stat_igrants    = stat_ig_q;
    assign o_stat_dgrants    = stat_dg_q;
    assign o_stat_contention = stat_ct_q;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: dut0 is round-robin, dut1 is dbus-priority; both TIMEOUT=8.
`timescale 1ns/1ps
module tb_cpu_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ireq = 1'b0, dreq = 1'b0, drw = 1'b0, bready = 1'b0;
    logic [31:0] iaddr = 32'h0, daddr = 32'h0, dwdata = 32'h0, brdata = 32'h0;
    logic [3:0]  dwmask = 4'h0;
    logic        p_ireq = 1'b0, p_dreq = 1'b0, p_bready = 1'b0;

    logic        ird0, drd0, brw0, breq0, fault0;
    logic [31:0] irdata0, drdata0, baddr0, bwdata0;
    logic [3:0]  bwmask0;
    logic [1:0]  grant0;
    logic        ird1, drd1, brw1, breq1, fault1;
    logic [31:0] irdata1, drdata1, baddr1, bwdata1;
    logic [3:0]  bwmask1;
    logic [1:0]  grant1;
`ifdef CPU_BUS_ARBITER_STATS_EN
    logic [31:0] sig0, sdg0, sct0, sig1, sdg1, sct1;
`endif

    int nchk = 0;
    int nerr = 0;

    cpu_bus_arbiter #(.PRIORITY(0), .TIMEOUT(8), .TW(16)) dut0 (
        .i_clock(clk), .i_reset(rst_n),
        .i_ibus_request(ireq), .o_ibus_ready(ird0), .i_ibus_address(iaddr),
        .o_ibus_rdata(irdata0), .i_dbus_rw(drw), .i_dbus_request(dreq),
        .o_dbus_ready(drd0), .i_dbus_address(daddr), .o_dbus_rdata(drdata0),
        .i_dbus_wdata(dwdata), .i_dbus_wmask(dwmask), .o_bus_rw(brw0),
        .o_bus_request(breq0), .i_bus_ready(bready), .o_bus_address(baddr0),
        .i_bus_rdata(brdata), .o_bus_wdata(bwdata0), .o_bus_wmask(bwmask0),
        .o_fault(fault0), .o_grant(grant0)
`ifdef CPU_BUS_ARBITER_STATS_EN
        , .o_stat_igrants(sig0), .o_stat_dgrants(sdg0), .o_stat_contention(sct0)
`endif
    );

    cpu_bus_arbiter #(.PRIORITY(1), .TIMEOUT(8), .TW(16)) dut1 (
        .i_clock(clk), .i_reset(rst_n),
        .i_ibus_request(p_ireq), .o_ibus_ready(ird1), .i_ibus_address(iaddr),
        .o_ibus_rdata(irdata1), .i_dbus_rw(drw), .i_dbus_request(p_dreq),
        .o_dbus_ready(drd1), .i_dbus_address(daddr), .o_dbus_rdata(drdata1),
        .i_dbus_wdata(dwdata), .i_dbus_wmask(dwmask), .o_bus_rw(brw1),
        .o_bus_request(breq1), .i_bus_ready(p_bready), .o_bus_address(baddr1),
        .i_bus_rdata(brdata), .o_bus_wdata(bwdata1), .o_bus_wmask(bwmask1),
        .o_fault(fault1), .o_grant(grant1)
`ifdef CPU_BUS_ARBITER_STATS_EN
        , .o_stat_igrants(sig1), .o_stat_dgrants(sdg1), .o_stat_contention(sct1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both sides hold requests for four transfers each; pat bit k = 1 means dbus wins transfer k.
    task automatic rr_run(input bit sel, input logic [7:0] pat);
        int il;
        int dl;
        int n;
        logic [1:0] g;
        il = 4;
        dl = 4;
        if (sel) begin
            p_ireq = 1'b1;
            p_dreq = 1'b1;
        end else begin
            ireq = 1'b1;
            dreq = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            n = 0;
            g = sel ? grant1 : grant0;
            while (g == 2'b00 && n < 10) begin
                step();
                n++;
                g = sel ? grant1 : grant0;
            end
            chk(sel ? "prio_grant" : "rr_grant", {30'h0, g}, pat[k] ? 32'h2 : 32'h1);
            if (sel) p_bready = 1'b1;
            else bready = 1'b1;
            step();
            p_bready = 1'b0;
            bready = 1'b0;
            if (g == 2'b10) begin
                chk("arb_dready", {31'h0, sel ? drd1 : drd0}, 32'h1);
                dl--;
                if (dl == 0) begin
                    if (sel) p_dreq = 1'b0;
                    else dreq = 1'b0;
                end
            end else begin
                chk("arb_iready", {31'h0, sel ? ird1 : ird0}, 32'h1);
                il--;
                if (il == 0) begin
                    if (sel) p_ireq = 1'b0;
                    else ireq = 1'b0;
                end
            end
        end
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_breq", {31'h0, breq0}, 32'h0);
        chk("rst_grant", {30'h0, grant0}, 32'h0);
        chk("rst_fault", {31'h0, fault0}, 32'h0);
        chk("rst_addr", baddr0, 32'h0);
        chk("rst_ready", {30'h0, ird0, drd0}, 32'h0);
        #10 rst_n = 1'b1;
        step();

        // Single ibus read, memory ready on the third grant cycle
        ireq = 1'b1;
        iaddr = 32'h100;
        step();
        chk("i_breq", {31'h0, breq0}, 32'h1);
        chk("i_grant", {30'h0, grant0}, 32'h1);
        chk("i_addr", baddr0, 32'h100);
        chk("i_rw_mask", {27'h0, brw0, bwmask0}, 32'h0);
        step();
        step();
        chk("i_wait_ready", {31'h0, ird0}, 32'h0);
        bready = 1'b1;
        brdata = 32'h13;
        step();
        bready = 1'b0;
        ireq = 1'b0;
        chk("i_ready", {31'h0, ird0}, 32'h1);
        chk("i_rdata", irdata0, 32'h13);
        chk("i_breq_drop", {31'h0, breq0}, 32'h0);
        chk("i_done_grant", {30'h0, grant0}, 32'h0);
        step();
        chk("i_ready_pulse", {31'h0, ird0}, 32'h0);
        step();
        chk("i_no_regrant", {30'h0, grant0}, 32'h0);

        // dbus write with an ibus request arriving mid-transfer
        dreq = 1'b1;
        drw = 1'b1;
        daddr = 32'h1000_0000;
        dwdata = 32'hCAFE_BABE;
        dwmask = 4'b0011;
        step();
        chk("d_grant", {30'h0, grant0}, 32'h2);
        chk("d_rw", {31'h0, brw0}, 32'h1);
        chk("d_wdata", bwdata0, 32'hCAFE_BABE);
        chk("d_wmask", {28'h0, bwmask0}, 32'h3);
        chk("d_addr", baddr0, 32'h1000_0000);
        ireq = 1'b1;
        iaddr = 32'h200;
        drw = 1'b0;
        daddr = 32'h0;
        dwdata = 32'h0;
        dwmask = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("d_addr_stable", baddr0, 32'h1000_0000);
            chk("d_grant_hold", {30'h0, grant0}, 32'h2);
        end
        bready = 1'b1;
        brdata = 32'h5555_AAAA;
        step();
        bready = 1'b0;
        dreq = 1'b0;
        chk("d_ready", {31'h0, drd0}, 32'h1);
        chk("d_rdata", drdata0, 32'h5555_AAAA);
        chk("d_ibus_untouched", {31'h0, ird0}, 32'h0);
        chk("d_ibus_rdata_kept", irdata0, 32'h13);
        step();
        chk("pend_idle", {30'h0, grant0}, 32'h0);
        step();
        chk("pend_grant_i", {30'h0, grant0}, 32'h1);
        chk("pend_addr", baddr0, 32'h200);
        chk("pend_rw", {31'h0, brw0}, 32'h0);
        bready = 1'b1;
        brdata = 32'h99;
        step();
        bready = 1'b0;
        ireq = 1'b0;
        chk("pend_ready", {31'h0, ird0}, 32'h1);
        chk("pend_rdata", irdata0, 32'h99);
        step();
        step();

        // Watchdog: memory never ready
        brdata = 32'hDEAD_BEEF;
        dreq = 1'b1;
        daddr = 32'h40;
        step();
        chk("wd_grant", {30'h0, grant0}, 32'h2);
        repeat (7) step();
        chk("wd_breq_held", {31'h0, breq0}, 32'h1);
        chk("wd_no_fault_yet", {31'h0, fault0}, 32'h0);
        step();
        dreq = 1'b0;
        chk("wd_breq_drop", {31'h0, breq0}, 32'h0);
        chk("wd_ready", {31'h0, drd0}, 32'h1);
        chk("wd_rdata_zero", drdata0, 32'h0);
        chk("wd_fault", {31'h0, fault0}, 32'h1);
        step();
        chk("wd_ready_pulse", {31'h0, drd0}, 32'h0);
        step();
        ireq = 1'b1;
        iaddr = 32'h400;
        step();
        chk("wd_after_grant", {30'h0, grant0}, 32'h1);
        bready = 1'b1;
        brdata = 32'h1234;
        step();
        bready = 1'b0;
        ireq = 1'b0;
        chk("wd_after_ready", {31'h0, ird0}, 32'h1);
        chk("wd_after_rdata", irdata0, 32'h1234);
        chk("wd_fault_sticky", {31'h0, fault0}, 32'h1);
        step();
        step();

        // Asynchronous reset mid-grant
        ireq = 1'b1;
        iaddr = 32'h300;
        step();
        chk("ar_grant", {30'h0, grant0}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_breq", {31'h0, breq0}, 32'h0);
        chk("ar_grant_clr", {30'h0, grant0}, 32'h0);
        chk("ar_fault_clr", {31'h0, fault0}, 32'h0);
        chk("ar_addr_clr", baddr0, 32'h0);
        chk("ar_rdata_clr", irdata0, 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("ar_regrant", {30'h0, grant0}, 32'h1);
        chk("ar_regrant_addr", baddr0, 32'h300);
        bready = 1'b1;
        brdata = 32'h77;
        step();
        bready = 1'b0;
        ireq = 1'b0;
        chk("ar_ready", {31'h0, ird0}, 32'h1);
        chk("ar_rdata", irdata0, 32'h77);
        step();
        step();

        // Arbitration under sustained contention
        iaddr = 32'h500;
        daddr = 32'h600;
        rr_run(1'b0, 8'b0101_0101);
        rr_run(1'b1, 8'b0000_1111);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
